// File: rtl/shared_net_drive_arbiter_pkg.sv
// Shared types and width helpers for the shared-net drive arbiter.
package shared_net_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_t;

  // Wide enough for TURN_CYC up to 7.
  localparam int unsigned TURN_CW = 3;

  // Width of an owner index for n drivers (at least one bit).
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_net_drive_arbiter_if.sv
// Driver-side request/data bundle and net enable/readback signals.
interface shared_net_drive_arbiter_if
  import shared_net_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 8
);
  localparam int unsigned IW = id_width(N_REQ);

  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    gnt;
  logic [IW-1:0]       owner_id;
  logic                bus_oe;
  logic [DW-1:0]       bus_dout;
  logic [DW-1:0]       bus_din;
  logic                err_clr;
  logic                contention_err;

  // Requesters and the net readback path.
  modport master (
    output req, req_data, bus_din, err_clr,
    input  gnt, owner_id, bus_oe, bus_dout, contention_err
  );

  // The arbiter.
  modport slave (
    input  req, req_data, bus_din, err_clr,
    output gnt, owner_id, bus_oe, bus_dout, contention_err
  );
endinterface

// File: rtl/shared_net_drive_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr.
module rr_pick
  import shared_net_arb_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IW    = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             any_req,
  output logic [IW-1:0]    winner
);

  int unsigned idx;

  // Scan from the pointer, wrapping, and keep the first hit.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (32'(ptr) + i) % N_REQ;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/shared_net_drive_arbiter.sv
// Shared-net ownership arbiter: round-robin grant, bus-off turnaround,
// hold-time preemption and readback contention detection.
// Optional: define BUS_PARK_EN to let the last owner keep driving in IDLE.
module shared_net_drive_arbiter
  import shared_net_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned DW       = 8,
  parameter int unsigned TURN_CYC = 1,
  parameter int unsigned MAX_HOLD = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  shared_net_drive_arbiter_if.slave bus
);

  localparam int unsigned IW = id_width(N_REQ);
  localparam int unsigned HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  arb_state_t           state_q, state_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [TURN_CW-1:0]   turn_q, turn_d;
  logic                 oe_q, oe_d;
  logic                 first_q, first_d;
  logic                 err_q, err_d;
  logic                 any_req;
  logic [IW-1:0]        win;
  logic                 grant;
  logic                 drop;
  logic                 force_rel;
  logic                 chk;
  logic [N_REQ-1:0]     others;
  logic [DW-1:0]        dout;
`ifdef BUS_PARK_EN
  logic                 parked_q, parked_d;
`endif

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .any_req (any_req),
    .winner  (win)
  );

  // Net data follows the registered owner; zero while not enabled.
  always_comb begin
    dout = oe_q ? bus.req_data[32'(owner_q)*DW +: DW] : '0;
  end

  assign bus.gnt            = gnt_q;
  assign bus.owner_id       = owner_q;
  assign bus.bus_oe         = oe_q;
  assign bus.bus_dout       = dout;
  assign bus.contention_err = err_q;

  // Release conditions and contention-check window.
  always_comb begin
    others    = bus.req & ~(N_REQ'(1) << owner_q);
    drop      = !bus.req[owner_q];
    force_rel = (MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD)) && (|others);
    chk       = (state_q == OWN) && !first_q;
`ifdef BUS_PARK_EN
    chk       = chk || ((state_q == IDLE) && oe_q);
`endif
  end

  // Next-state, grant and counter logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    oe_d    = oe_q;
    first_d = 1'b0;
    grant   = 1'b0;
`ifdef BUS_PARK_EN
    parked_d = parked_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
`ifdef BUS_PARK_EN
          if (parked_q && (win != owner_q)) begin
            state_d = TURN;
            turn_d  = TURN_CW'(TURN_CYC - 1);
            oe_d    = 1'b0;
          end else begin
            grant = 1'b1;
          end
`else
          grant = 1'b1;
`endif
        end
      end
      OWN: begin
        if (drop || force_rel) begin
          state_d = TURN;
          turn_d  = TURN_CW'(TURN_CYC - 1);
          gnt_d   = '0;
          oe_d    = 1'b0;
        end else if (hold_q < HW'(MAX_HOLD)) begin
          hold_d = hold_q + HW'(1);
        end
      end
      TURN: begin
        if (turn_q == '0) begin
          if (any_req) begin
            grant = 1'b1;
          end else begin
            state_d = IDLE;
`ifdef BUS_PARK_EN
            oe_d = parked_q;
`else
            oe_d = 1'b0;
`endif
          end
        end else begin
          turn_d = turn_q - TURN_CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant) begin
      state_d = OWN;
      gnt_d   = N_REQ'(1) << win;
      owner_d = win;
      ptr_d   = (win == IW'(N_REQ - 1)) ? '0 : win + IW'(1);
      hold_d  = HW'(1);
      oe_d    = 1'b1;
      first_d = 1'b1;
`ifdef BUS_PARK_EN
      parked_d = 1'b1;
`endif
    end
  end

  // Sticky contention flag; a new mismatch beats a clear.
  always_comb begin
    err_d = err_q;
    if (chk && (bus.bus_din != dout)) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
      oe_q    <= 1'b0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef BUS_PARK_EN
      parked_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      oe_q    <= oe_d;
      first_q <= first_d;
      err_q   <= err_d;
`ifdef BUS_PARK_EN
      parked_q <= parked_d;
`endif
    end
  end

endmodule
